// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported memory bus between instruction fetch and
//   load/store. Each access is arbitrated in IDLE, then held on the bus
//   (BUSY_I / BUSY_D) until mem_ack or watchdog abort, then answered with a
//   one-cycle response pulse (RESP).
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   i_req/i_addr      fetch request and address
//   i_rdata/i_valid   instruction word and its one-cycle completion pulse
//   d_req/d_we/d_be/d_addr/d_wdata   load/store request
//   d_rdata/d_done    load data and its one-cycle completion pulse
//   fetch_stall       (i_req & ~i_valid) | (d_req & ~d_done), combinational
//   mem_req/mem_we/mem_be/mem_addr/mem_wdata   registered memory bus request
//   mem_rdata/mem_ack memory read data and completion
//   bus_err           one-cycle pulse in RESP of a timed-out access
//
// Configuration
//   ARB_ROUND_ROBIN_EN  defined: alternate grants when both requesters are
//                       pending. Undefined: data always wins over fetch.
module mem_port_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic [DATA_W-1:0]   i_rdata,
    output logic                i_valid,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_done,
    output logic                fetch_stall,
    output logic                mem_req,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ack,
    output logic                bus_err
);

    localparam int BE_W  = DATA_W / 8;
    // A zero limit disables the watchdog; keep a 1-bit counter so widths stay legal.
    localparam int CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
    localparam bit WDOG_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;

    state_t              state_q, state_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [BE_W-1:0]     mem_be_q, mem_be_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic                i_valid_q, i_valid_d;
    logic                d_done_q, d_done_d;
    logic                bus_err_q, bus_err_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic prefer_d;
    logic grant_d;
    logic grant_i;
    logic timeout_hit;

`ifdef ARB_ROUND_ROBIN_EN
    // last_grant_q: 1 = data was granted last, 0 = fetch.
    logic last_grant_q, last_grant_d;
    assign prefer_d = ~last_grant_q;
`else
    assign prefer_d = 1'b1;
`endif

    // Data wins a conflict when preferred; a lone requester always wins.
    assign grant_d = d_req & (~i_req | prefer_d);
    assign grant_i = i_req & ~grant_d;

    // The abort fires on the edge where the counter would reach the limit,
    // giving exactly TIMEOUT_CYCLES busy cycles.
    assign timeout_hit = WDOG_EN && (cnt_q == CNT_LAST);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: RESP never arbitrates, so a requester gets one cycle
    // to update its request before the next grant.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    state_d = BUSY_D;
                end else if (grant_i) begin
                    state_d = BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_ack || timeout_hit) begin
                    state_d = RESP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output/datapath next values: bus latch on grant, data capture on
    // completion, response pulses for the RESP cycle, watchdog counting.
    always_comb begin
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        i_valid_d   = 1'b0;
        d_done_d    = 1'b0;
        bus_err_d   = 1'b0;
        cnt_d       = cnt_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we;
                    mem_be_d    = d_be;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    cnt_d       = '0;
`ifdef ARB_ROUND_ROBIN_EN
                    last_grant_d = 1'b1;
`endif
                end else if (grant_i) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_be_d    = '1;
                    mem_addr_d  = i_addr;
                    mem_wdata_d = '0;
                    cnt_d       = '0;
`ifdef ARB_ROUND_ROBIN_EN
                    last_grant_d = 1'b0;
`endif
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_ack || timeout_hit) begin
                    // An aborted access returns zero data and flags bus_err.
                    mem_req_d = 1'b0;
                    bus_err_d = ~mem_ack;
                    if (state_q == BUSY_I) begin
                        i_valid_d = 1'b1;
                        i_rdata_d = mem_ack ? mem_rdata : '0;
                    end else begin
                        d_done_d = 1'b1;
                        if (!mem_we_q) begin
                            d_rdata_d = mem_ack ? mem_rdata : '0;
                        end
                    end
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers; reset abandons any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            i_valid_q   <= 1'b0;
            d_done_q    <= 1'b0;
            bus_err_q   <= 1'b0;
            cnt_q       <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_q <= 1'b0;
`endif
        end else begin
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            i_valid_q   <= i_valid_d;
            d_done_q    <= d_done_d;
            bus_err_q   <= bus_err_d;
            cnt_q       <= cnt_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_be      = mem_be_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign i_rdata     = i_rdata_q;
    assign d_rdata     = d_rdata_q;
    assign i_valid     = i_valid_q;
    assign d_done      = d_done_q;
    assign bus_err     = bus_err_q;
    assign fetch_stall = (i_req & ~i_valid_q) | (d_req & ~d_done_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Self-checking bench for mem_port_arbiter with a 4-cycle watchdog.
//   A table of single-requester accesses plus hand-written sequences for
//   arbitration, timeout, reset mid-access and back-to-back fetches.
//   Expected bus requests and responses live in a scoreboard queue.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_req = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic [DW-1:0] i_rdata;
    logic          i_valid;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [BW-1:0] d_be = '0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic [DW-1:0] d_rdata;
    logic          d_done;
    logic          fetch_stall;
    logic          mem_req;
    logic          mem_we;
    logic [BW-1:0] mem_be;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_ack = 1'b0;
    logic          bus_err;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_valid(i_valid),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done), .fetch_stall(fetch_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          isData;
        bit          we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        bit          busErr;
    } exp_t;

    typedef struct {
        bit          isData;
        bit          we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waits;
        logic [31:0] expRdata;
        int          expLat;
    } vec_t;

    exp_t        expQ[$];
    int          testsRun = 0;
    int          testsFailed = 0;
    int          waitStates = 0;
    int          waitCnt = 0;
    bit          ackEnable = 1'b1;
    int          reqCycles = 0;
    logic [31:0] holdI = '0;
    logic [31:0] holdD = '0;
    bit          lastGrantD = 1'b0;

    // Memory contents: one fixed instruction, everything else address-derived.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        if (a == 32'h8000_0000) return 32'h0000_0013;
        return a ^ 32'h5A5A_5A5A;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic pushExp(input bit isData, input bit we, input logic [3:0] be,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata, input bit busErr);
        exp_t e;
        e.isData = isData; e.we = we; e.be = be; e.addr = addr;
        e.wdata = wdata; e.rdata = rdata; e.busErr = busErr;
        expQ.push_back(e);
        lastGrantD = isData;
    endtask

    // Memory responder: acks after waitStates cycles of mem_req.
    task automatic respond();
        if (mem_req && ackEnable) begin
            if (waitCnt >= waitStates) begin
                mem_ack   = 1'b1;
                mem_rdata = memWord(mem_addr);
            end else begin
                mem_ack = 1'b0;
                waitCnt++;
            end
        end else begin
            mem_ack   = 1'b0;
            waitCnt   = 0;
            mem_rdata = 32'hBAD0_0000;
        end
    endtask

    // Scoreboard: checks every bus cycle against the head entry and pops
    // it on the response pulse.
    task automatic monitorStep();
        exp_t e;
        if (rst) begin
            holdI = '0;
            holdD = '0;
            return;
        end
        if (mem_req) begin
            if (expQ.size() == 0) begin
                check("spurious mem_req", mem_req, 0);
            end else begin
                check("mem_addr", mem_addr, expQ[0].addr);
                check("mem_we", mem_we, expQ[0].we);
                check("mem_be", mem_be, expQ[0].be);
                check("mem_wdata", mem_wdata, expQ[0].wdata);
            end
            reqCycles++;
        end
        if (i_valid || d_done) begin
            check("mem_req in RESP", mem_req, 0);
            if (expQ.size() == 0) begin
                check("spurious response", i_valid | d_done, 0);
            end else begin
                e = expQ.pop_front();
                check("d_done", d_done, e.isData);
                check("i_valid", i_valid, !e.isData);
                check("bus_err", bus_err, e.busErr);
                if (e.isData) begin
                    check("d_rdata", d_rdata, e.rdata);
                    check("i_rdata hold", i_rdata, holdI);
                    holdD = e.rdata;
                end else begin
                    check("i_rdata", i_rdata, e.rdata);
                    check("d_rdata hold", d_rdata, holdD);
                    holdI = e.rdata;
                end
            end
        end else begin
            check("bus_err outside RESP", bus_err, 0);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        respond();
        monitorStep();
    endtask

    task automatic applyStimulus(input vec_t v);
        if (v.isData) begin
            d_we = v.we; d_be = v.be; d_addr = v.addr; d_wdata = v.wdata; d_req = 1'b1;
        end else begin
            i_addr = v.addr; i_req = 1'b1;
        end
    endtask

    // One table access: drive, wait for the response, check latency and stall.
    task automatic checkOutput(input vec_t v, input int idx);
        int  lat;
        bit  seen;
        bit  stallOk;
        logic stallAtResp;
        seen = 1'b0; stallOk = 1'b1; stallAtResp = 1'b1;
        for (lat = 1; lat <= 20; lat++) begin
            tick();
            if (i_valid || d_done) begin
                seen = 1'b1;
                stallAtResp = fetch_stall;
                break;
            end
            if (!fetch_stall) stallOk = 1'b0;
        end
        #1;
        i_req = 1'b0;
        d_req = 1'b0;
        check($sformatf("vec%0d response seen", idx), seen, 1);
        check($sformatf("vec%0d latency", idx), lat, v.expLat);
        check($sformatf("vec%0d mem_req cycles", idx), reqCycles, v.waits + 1);
        check($sformatf("vec%0d stall while waiting", idx), stallOk, 1);
        check($sformatf("vec%0d stall in RESP", idx), stallAtResp, 0);
        tick();
        #1;
    endtask

    initial begin
        vec_t vecs[7];
        int   lat;
        bit   seen;
        bit   gotI, gotD, firstD, expFirstD;
        int   nResp, firstAt, secondAt;

        vecs[0] = '{0, 0, 4'hF, 32'h8000_0000, 32'h0,         0, 32'h0000_0013, 2};
        vecs[1] = '{1, 1, 4'h3, 32'h0000_0100, 32'hDEAD_BEEF, 2, 32'h0000_0000, 4};
        vecs[2] = '{1, 0, 4'hF, 32'h0000_0200, 32'h0,         0, 32'h5A5A_585A, 2};
        vecs[3] = '{1, 0, 4'hF, 32'h0000_0204, 32'h0,         1, 32'h5A5A_585E, 3};
        vecs[4] = '{0, 0, 4'hF, 32'h8000_0010, 32'h0,         3, 32'hDA5A_5A4A, 5};
        vecs[5] = '{1, 1, 4'hF, 32'h0000_0300, 32'h1234_5678, 0, 32'h5A5A_585E, 2};
        vecs[6] = '{1, 0, 4'h1, 32'h0000_0040, 32'h0,         2, 32'h5A5A_5A1A, 4};

        // Reset values; fetch_stall follows i_req even in reset.
        i_req = 1'b1;
        tick(); tick();
        check("reset mem_req", mem_req, 0);
        check("reset mem_addr", mem_addr, 0);
        check("reset mem_be", mem_be, 0);
        check("reset mem_we", mem_we, 0);
        check("reset mem_wdata", mem_wdata, 0);
        check("reset i_valid", i_valid, 0);
        check("reset d_done", d_done, 0);
        check("reset bus_err", bus_err, 0);
        check("reset i_rdata", i_rdata, 0);
        check("reset d_rdata", d_rdata, 0);
        check("reset fetch_stall", fetch_stall, 1);
        #1 i_req = 1'b0;
        #1 check("reset fetch_stall idle", fetch_stall, 0);
        tick();
        #1 rst = 1'b0;
        tick();
        #1;

        // Single-requester table.
        for (int k = 0; k < 7; k++) begin
            waitStates = vecs[k].waits;
            reqCycles  = 0;
            pushExp(vecs[k].isData, vecs[k].we, vecs[k].isData ? vecs[k].be : 4'hF,
                    vecs[k].addr, vecs[k].isData ? vecs[k].wdata : 32'h0,
                    vecs[k].expRdata, 1'b0);
            applyStimulus(vecs[k]);
            checkOutput(vecs[k], k);
        end

        // Watchdog: no ack, four busy cycles then an error response.
        ackEnable = 1'b0;
        reqCycles = 0;
        pushExp(0, 0, 4'hF, 32'h8000_0040, 32'h0, 32'h0, 1'b1);
        i_addr = 32'h8000_0040; i_req = 1'b1;
        seen = 1'b0;
        for (lat = 1; lat <= 20; lat++) begin
            tick();
            if (i_valid) begin seen = 1'b1; break; end
        end
        #1 i_req = 1'b0;
        ackEnable = 1'b1;
        check("timeout response seen", seen, 1);
        check("timeout busy cycles", reqCycles, TO);
        check("timeout latency", lat, TO + 1);
        tick(); #1;

        // Reset while a load is on the bus: abandoned, then re-granted.
        waitStates = 5;
        pushExp(1, 0, 4'hF, 32'h0000_0200, 32'h0, memWord(32'h200), 1'b0);
        d_we = 1'b0; d_be = 4'hF; d_addr = 32'h0000_0200; d_wdata = 32'h0; d_req = 1'b1;
        tick();
        check("rst test busy", mem_req, 1);
        #1 rst = 1'b1;
        #1 check("async mem_req drop", mem_req, 0);
        expQ.delete();
        lastGrantD = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            check("no d_done after reset", d_done, 0);
        end
        #1;
        waitStates = 0;
        pushExp(1, 0, 4'hF, 32'h0000_0200, 32'h0, memWord(32'h200), 1'b0);
        rst = 1'b0;
        seen = 1'b0;
        for (lat = 1; lat <= 20; lat++) begin
            tick();
            if (d_done) begin seen = 1'b1; break; end
        end
        #1 d_req = 1'b0;
        check("regrant after reset", seen, 1);
        check("regrant latency", lat, 2);
        tick(); #1;

        // Both requesters pending in IDLE.
`ifdef ARB_ROUND_ROBIN_EN
        expFirstD = !lastGrantD;
`else
        expFirstD = 1'b1;
`endif
        if (expFirstD) begin
            pushExp(1, 0, 4'hF, 32'h0000_0200, 32'h0, memWord(32'h200), 1'b0);
            pushExp(0, 0, 4'hF, 32'h8000_0020, 32'h0, memWord(32'h8000_0020), 1'b0);
        end else begin
            pushExp(0, 0, 4'hF, 32'h8000_0020, 32'h0, memWord(32'h8000_0020), 1'b0);
            pushExp(1, 0, 4'hF, 32'h0000_0200, 32'h0, memWord(32'h200), 1'b0);
        end
        i_addr = 32'h8000_0020; i_req = 1'b1;
        d_we = 1'b0; d_be = 4'hF; d_addr = 32'h0000_0200; d_req = 1'b1;
        gotI = 1'b0; gotD = 1'b0; firstD = 1'b0;
        for (int c = 0; c < 30 && !(gotI && gotD); c++) begin
            tick();
            if (d_done) begin
                if (!gotI) firstD = 1'b1;
                gotD = 1'b1;
                #1 d_req = 1'b0;
            end
            if (i_valid) begin
                gotI = 1'b1;
                #1 i_req = 1'b0;
            end
        end
        i_req = 1'b0; d_req = 1'b0;
        check("both served", {gotI, gotD}, 2'b11);
        check("grant order", firstD, expFirstD);
        tick(); #1;

        // Back-to-back fetches: second address follows RESP with no repeat.
        pushExp(0, 0, 4'hF, 32'h8000_0000, 32'h0, memWord(32'h8000_0000), 1'b0);
        pushExp(0, 0, 4'hF, 32'h8000_0004, 32'h0, memWord(32'h8000_0004), 1'b0);
        i_addr = 32'h8000_0000; i_req = 1'b1;
        nResp = 0; firstAt = 0; secondAt = 0;
        for (int c = 1; c <= 30 && nResp < 2; c++) begin
            tick();
            if (i_valid) begin
                nResp++;
                if (nResp == 1) begin
                    firstAt = c;
                    #1 i_addr = 32'h8000_0004;
                end else begin
                    secondAt = c;
                    #1 i_req = 1'b0;
                end
            end
        end
        i_req = 1'b0;
        check("back-to-back responses", nResp, 2);
        check("back-to-back spacing", secondAt - firstAt, 3);

        repeat (3) tick();
        check("scoreboard drained", expQ.size(), 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
